// File: rtl/debounce_sync.sv
// Switch/button debouncer: a synchronizer chain followed by a four-state
// stability checker that drives a registered level and one-cycle edge pulses.
module debounce_sync #(
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_COUNT = 10,
  parameter int CNT_W        = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  typedef enum logic [1:0] {
    LOW    = 2'd0,
    CHK_HI = 2'd1,
    HIGH   = 2'd2,
    CHK_LO = 2'd3
  } state_e;

  // One extra bit so STABLE_COUNT = 2**CNT_W is representable without wrap.
  localparam logic [CNT_W:0] CNT_MAX  = (CNT_W+1)'(STABLE_COUNT);
  localparam logic [CNT_W:0] CNT_ONE  = (CNT_W+1)'(1);
  localparam logic [CNT_W:0] CNT_ZERO = '0;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  state_e         state_q, state_d;
  logic [CNT_W:0] cnt_q, cnt_d;
  logic           q_q, q_d;
  logic           rise_q, rise_d;
  logic           fall_q, fall_d;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would collapse the chain into one stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOW;
      cnt_q   <= CNT_ZERO;
      q_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    unique case (state_q)
      LOW: begin
        if (s) begin
          state_d = CHK_HI;
          cnt_d   = CNT_ONE;
        end
      end
      CHK_HI: begin
        if (!s) begin
          state_d = LOW;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HIGH;
          cnt_d   = CNT_ZERO;
          q_d     = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HIGH: begin
        if (!s) begin
          state_d = CHK_LO;
          cnt_d   = CNT_ONE;
        end
      end
      CHK_LO: begin
        if (s) begin
          state_d = HIGH;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = LOW;
          cnt_d   = CNT_ZERO;
          q_d     = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = CNT_ZERO;
        q_d     = 1'b0;
      end
    endcase
  end

  assign q    = q_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: doc/debounce_sync.md
DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on d (legal 2..4).
REQ-002 The block SHALL have parameter STABLE_COUNT, default 10: consecutive cycles the synchronized input must differ from q before q updates (legal 1..2^CNT_W).
REQ-003 The block SHALL have parameter CNT_W, default 4: width of the stability counter.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all flops update on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port d, input, 1 bit: raw asynchronous level, e.g. a switch or button.
REQ-007 The block SHALL have port q, output, 1 bit: debounced, synchronized level, registered, suitable as the d input of a downstream flip-flop stage.
REQ-008 The block SHALL have port rise, output, 1 bit: one-cycle pulse when q goes 0->1.
REQ-009 The block SHALL have port fall, output, 1 bit: one-cycle pulse when q goes 1->0.

Function
REQ-010 d SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is s; no logic SHALL sit between chain stages.
REQ-011 The control FSM SHALL have four states: LOW (q=0, s=0), CHK_HI (q=0, counting s=1), HIGH (q=1, s=1), CHK_LO (q=1, counting s=0).
REQ-012 LOW -> CHK_HI SHALL occur when s=1; the counter SHALL load 1 on that edge.
REQ-013 In CHK_HI, if s=0 the FSM SHALL return to LOW, clear the counter, and leave q unchanged.
REQ-014 In CHK_HI, if s=1 and counter < STABLE_COUNT, the counter SHALL increment.
REQ-015 In CHK_HI, if s=1 and counter = STABLE_COUNT, the FSM SHALL go to HIGH, set q=1, pulse rise, and clear the counter, all on the same edge.
REQ-016 HIGH, CHK_LO and fall SHALL behave symmetrically to REQ-012..015, with s inverted.
REQ-017 With STABLE_COUNT=1, q SHALL change on the edge after s first differs, passing through CHK_* for exactly one cycle.
REQ-018 Total latency from a clean d change (set up before edge 0) to q changing SHALL be SYNC_STAGES+STABLE_COUNT rising edges.
REQ-019 Any excursion of s shorter than STABLE_COUNT+1 consecutive cycles SHALL leave q, rise and fall unchanged.
REQ-020 rise and fall SHALL be registered, high for exactly one cycle, and never high simultaneously.
REQ-021 q SHALL change at most once per STABLE_COUNT+1 cycles.
REQ-022 The counter SHALL never exceed STABLE_COUNT and never wrap.

Reset
REQ-023 While rst_n=0, all sync flops, q, rise and fall SHALL be 0, the counter SHALL be 0, and the FSM SHALL be in LOW, taking effect immediately without a clock.
REQ-024 Deassertion of rst_n SHALL be honored at the next rising edge; if d=1 at that time, q SHALL rise after the standard REQ-018 latency, with rise pulsed.
REQ-025 Reset asserted mid-count SHALL abandon the count; no rise or fall SHALL be emitted for the interrupted transition.

Verification (defaults: SYNC_STAGES=2, STABLE_COUNT=10)
REQ-026 Reset release with d=0 held for 50 cycles -> q=0, rise=0, fall=0 throughout.
REQ-027 d 0->1 before edge 0 and held -> q=1 and rise=1 after edge 12; rise=0 after edge 13; fall never asserts.
REQ-028 d=1 pulse lasting 10 cycles, then d=0 -> q stays 0, no rise; counter returns to 0.
REQ-029 d chattering (toggle every 3 cycles) for 40 cycles then stable 1 -> q=1 exactly 12 edges after the last d edge, with a single rise pulse.
REQ-030 q=1 stable; d->0; rst_n pulsed low at count 5 -> q=0 immediately, no fall pulse; after release, d=0 -> q remains 0.
REQ-031 STABLE_COUNT=1 build, d 0->1 -> q=1 after edge 3; d 1->0 -> q=0 three edges later, with fall pulsed once.
